// File: rtl/cla_pkg.sv
// Shared constants, helpers and the stage-register bundle for the pipelined CLA adder.
package cla_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int SEG_DEF   = 16;
  localparam int SLICE     = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Lower sum segments are filled in stage by stage; a/b travel along until consumed.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic                 c_msb;
    logic [WIDTH_DEF-1:0] sum;
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
  } stage_t;

endpackage

// File: rtl/cla64_pipe_if.sv
// Operand-side and result-side valid/ready bundle of the pipelined adder.
interface cla64_pipe_if import cla_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/adder4.sv
// 4-bit carry-look-ahead slice: all internal carries from generate/propagate terms.
module adder4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic       w_c1;
  logic       w_c2;
  logic       w_c3;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  assign w_c1 = w_g[0] | (w_p[0] & i_cin);
  assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign o_cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum = w_p ^ {w_c3, w_c2, w_c1, i_cin};

endmodule

// File: rtl/cla_seg.sv
// Combinational SEG-bit adder: a ripple of 4-bit CLA slices, one segment per pipe stage.
module cla_seg import cla_pkg::*; #(
  parameter int SEG = SEG_DEF
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout,
  output logic           o_c_msb
);

  localparam int NSL = SEG / SLICE;

  for (genvar gi = 0; gi < NSL; gi++) begin : g_slice
    logic w_ci;
    logic w_co;

    if (gi == 0) begin : g_first
      assign w_ci = i_cin;
    end else begin : g_next
      assign w_ci = g_slice[gi-1].w_co;
    end

    adder4 u_slice (
      .i_a    (i_a[gi*SLICE +: SLICE]),
      .i_b    (i_b[gi*SLICE +: SLICE]),
      .i_cin  (w_ci),
      .o_sum  (o_sum[gi*SLICE +: SLICE]),
      .o_cout (w_co)
    );
  end

  assign o_cout  = g_slice[NSL-1].w_co;
  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
  assign o_c_msb = i_a[SEG-1] ^ i_b[SEG-1] ^ o_sum[SEG-1];

endmodule

// File: rtl/cla64_pipe.sv
// Pipelined carry-look-ahead adder: one SEG-bit segment per stage, registered inter-segment carry.
// WIDTH must be a multiple of SEG and no larger than WIDTH_DEF; SEG must be a multiple of 4.
module cla64_pipe import cla_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG   = SEG_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  cla64_pipe_if.slave  bus
);

  localparam int STAGES = WIDTH / SEG;

  stage_t w_q [STAGES];
  logic   w_en;

  // The whole pipe moves together; it only stalls when a finished result is not taken.
  assign w_en         = !w_q[STAGES-1].valid || bus.out_ready;
  assign bus.in_ready = w_en;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    stage_t         w_src;
    stage_t         w_nxt;
    stage_t         r_q;
    logic [SEG-1:0] w_seg_sum;
    logic           w_seg_cout;
    logic           w_seg_cmsb;

    if (gi == 0) begin : g_head
      assign w_src = '{valid: bus.in_valid,
                       carry: bus.in_cin,
                       c_msb: 1'b0,
                       sum:   {WIDTH_DEF{1'b0}},
                       a:     WIDTH_DEF'(bus.in_a),
                       b:     WIDTH_DEF'(bus.in_b)};
    end else begin : g_chain
      assign w_src = w_q[gi-1];
    end

    cla_seg #(.SEG(SEG)) u_seg (
      .i_a     (w_src.a[gi*SEG +: SEG]),
      .i_b     (w_src.b[gi*SEG +: SEG]),
      .i_cin   (w_src.carry),
      .o_sum   (w_seg_sum),
      .o_cout  (w_seg_cout),
      .o_c_msb (w_seg_cmsb)
    );

    always_comb begin
      w_nxt                    = w_src;
      w_nxt.sum[gi*SEG +: SEG] = w_seg_sum;
      w_nxt.carry              = w_seg_cout;
      w_nxt.c_msb              = w_seg_cmsb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (w_en) begin
        r_q <= w_nxt;
      end
    end

    assign w_q[gi] = r_q;
  end

  assign bus.out_valid = w_q[STAGES-1].valid;
  assign bus.out_sum   = w_q[STAGES-1].sum[WIDTH-1:0];
  assign bus.out_cout  = w_q[STAGES-1].carry;
  assign bus.out_ovf   = w_q[STAGES-1].carry ^ w_q[STAGES-1].c_msb;

endmodule

// File: doc/cla64_pipe.md
Name: cla64_pipe

Overview:
- Pipelined 64-bit carry-look-ahead adder with valid/ready handshake on both sides.
- Splits the operand width into STAGES segments of SEG bits. Each segment is a ripple of 4-bit CLA slices, which are the existing adder4 blocks.
- The inter-segment carry is registered, so one add issues per cycle at full rate.
- Sits between the operand-issue logic upstream and the result consumer downstream. It is the top-level datapath around the 4-bit slices.

Parameters:
- WIDTH, 64, operand/sum width; must be a multiple of SEG.
- SEG, 16, bits resolved per pipeline stage; must be a multiple of 4.
- STAGES, WIDTH/SEG (4), derived pipeline depth; not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts operand beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in to bit 0
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result this cycle
- out_sum  out  WIDTH  A+B+cin, modulo 2^WIDTH
- out_cout  out  1  carry out of bit WIDTH-1
- out_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset is asynchronous and active-low: rst_n.
  - While rst_n=0: every stage valid bit is 0, all data registers are 0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
- Global advance enable: en = !out_valid || out_ready.
  - in_ready = en (combinational).
  - When en=0 the whole pipeline holds and no register changes.
- Transfer rules:
  - Input transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
- Stage k (0..STAGES-1), when en=1:
  - Adds segment k of A and B plus the carry from stage k-1 (stage 0 uses in_cin).
  - Registers: segment-k sum, carry-out, and the not-yet-processed upper operand segments.
  - Lower sum segments already produced are carried forward unchanged (skew/deskew registers).
  - The stage valid bit shifts from stage k-1; stage 0 loads in_valid.
- Latency and throughput:
  - Exactly STAGES cycles from input transfer to out_valid, i.e. 4 at defaults, with no stall.
  - Throughput is 1 result per cycle when out_ready is held 1.
- Bubbles: not collapsed. An invalid beat advances like a valid one, and stage data is don't-care when its valid bit is 0.
- Ordering: strictly in order, no reordering, no drops.
- Backpressure: while out_valid=1 and out_ready=0, out_sum, out_cout and out_ovf are held stable, and in_ready=0.
- Overflow: out_ovf uses the carry into bit WIDTH-1, which is taken from the last slice's internal c3 or recomputed from a[MSB]^b[MSB]^sum[MSB].
- Wrap-around: the sum is modulo 2^WIDTH, with the carry reported only on out_cout.
- Simultaneous output and input transfer in the same cycle is legal and is the steady-state case.
- Reset mid-operation: all in-flight beats are discarded with no output. The first accepted beat after rst_n deasserts appears STAGES cycles later.
- in_valid while in_ready=0: the beat is not captured, and upstream must hold its data.

Decomposition:
- Shared package (cla_pkg):
  - Constants WIDTH_DEF=64, SEG_DEF=16, SLICE=4.
  - Function clog2.
  - Typedef for the stage-register bundle: sum segment, carry, remaining operands, valid.
- Sub-module cla_seg:
  - Combinational SEG-bit adder built from SEG/4 chained adder4 slices.
  - Outputs: sum, cout, and the carry into its MSB.
  - Instantiated once per stage.
- Pipeline registers, enable and handshake logic live in cla64_pipe.

Test Plan:
- Carry across segment boundary: a=0x0000_0000_0000_FFFF, b=0x1, cin=0 -> after 4 cycles out_sum=0x0000_0000_0001_0000, cout=0, ovf=0.
- Full carry ripple through all stages: a=0xFFFF_FFFF_FFFF_FFFF, b=0x0, cin=1 -> out_sum=0x0, cout=1, ovf=0.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> out_sum=0x8000_0000_0000_0000, cout=0, ovf=1. Separately, a=b=0x8000_0000_0000_0000 -> out_sum=0, cout=1, ovf=1.
- Streaming: 16 back-to-back random beats with out_ready=1 -> 16 results on consecutive cycles starting cycle 4, in order, each matching a reference model.
- Backpressure: drop out_ready for 3 cycles while 4 beats are in flight -> in_ready=0 and outputs frozen for those 3 cycles. Every result is still delivered exactly once, in order, after out_ready returns.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately (asynchronously), and none of those 3 beats ever appears. After release, a beat of 0x5+0x3 gives out_sum=0x8 after 4 cycles.
